// File: rtl/mmio_pkg.sv
// +--------------------------------------------------------------------------+
// | mmio_pkg : shared types and constants for the MMIO console transmitter   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_HALT  = 3;
  localparam int STAT_OVF   = 4;

  // Default console/halt addresses; SoC integration overrides them from the common defs.
  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_HALT_ADDR    = 32'h1000_0010;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +--------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, show-ahead read, push accepted when full  |
// |             only if a pop happens on the same edge                       |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_do_push, w_do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    w_do_pop  = pop && !empty;
    w_do_push = push && (!full || w_do_pop);
    wr_ptr_d  = w_do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = w_do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/mmio_console_tx.sv
// +--------------------------------------------------------------------------+
// | mmio_console_tx : console/halt MMIO responder, FIFO-buffered 8N1 UART TX |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module mmio_console_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
  parameter logic [31:0] HALT_ADDR    = DEF_HALT_ADDR,
  parameter logic [31:0] STATUS_ADDR  = CONSOLE_ADDR + 32'd4,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        mmio_hit,
  output logic [31:0] mmio_rdata,
  output logic        uart_tx,
  output logic        halt_req
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;
  logic        halt_pend_q, halt_pend_d;
  logic        halt_req_q, halt_req_d;

  logic        w_con_hit, w_halt_hit, w_stat_hit;
  logic        w_push, w_pop, w_baud_end;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_unused   = ^writedata[31:8];
  assign w_con_hit  = (dataadr == CONSOLE_ADDR);
  assign w_halt_hit = (dataadr == HALT_ADDR);
  assign w_stat_hit = (dataadr == STATUS_ADDR);
  assign mmio_hit   = w_con_hit || w_halt_hit || w_stat_hit;
  assign w_push     = memwrite && w_con_hit;
  assign w_pop      = (state_q == IDLE) && !fifo_empty;
  assign w_baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (writedata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    w_status             = '0;
    w_status[STAT_EMPTY] = fifo_empty;
    w_status[STAT_FULL]  = fifo_full;
    w_status[STAT_BUSY]  = (state_q != IDLE);
    w_status[STAT_HALT]  = halt_pend_q;
    w_status[STAT_OVF]   = ovf_q;
    mmio_rdata           = w_stat_hit ? w_status : 32'h0;
  end

  // A full FIFO still accepts if the transmitter drains one entry on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (memwrite && w_stat_hit && writedata[STAT_OVF]) ovf_d = 1'b0;
    if (w_push && (fifo_count == CW'(FIFO_DEPTH)) && !w_pop) ovf_d = 1'b1;
    halt_pend_d = halt_pend_q || (memwrite && w_halt_hit);
    halt_req_d  = halt_req_q || (halt_pend_q && fifo_empty && (state_q == IDLE));
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (w_pop) begin
          shift_d = fifo_rdata;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (w_baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else baud_d = baud_q + BW'(1);
      end
      DATA: begin
        if (w_baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else baud_d = baud_q + BW'(1);
      end
      STOP: begin
        if (w_baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else baud_d = baud_q + BW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // The line is registered, so it trails the FSM state by one clock.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      tx_q        <= 1'b1;
      ovf_q       <= 1'b0;
      halt_pend_q <= 1'b0;
      halt_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ovf_q       <= ovf_d;
      halt_pend_q <= halt_pend_d;
      halt_req_q  <= halt_req_d;
    end
  end

  assign uart_tx  = tx_q;
  assign halt_req = halt_req_q;

endmodule

`default_nettype wire
